uart_rx_port: RTL and testbench
===============================

// Module: uart_rx_port
// PURPOSE
// - Memory-mapped serial input port: receives 8N1 UART frames on UART_RXD and presents them on the
//   processor's data-read path, the input-side counterpart of the parallel output port.
// - Sits between the data memory and the MemtoReg mux, beside the parallel input port; the CPU reads
//   received bytes and status with ordinary loads from two reserved addresses.
// PARAMETERS
// CLK_FREQ   50000000  iCLK frequency in Hz
// BAUD       115200    line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, 434 at defaults)
// DATA_ADDR  8'hFE     load address returning the received byte
// STAT_ADDR  8'hFD     load address returning status {5'b0, frame_err, overrun, valid}
// PORTS
// iCLK       in   1  system clock (CLOCK_50)
// iRST_N     in   1  synchronous reset, active-low
// iRXD       in   1  asynchronous serial line, idle high
// iAddress   in   8  load address (ALU result)
// iMemData   in   8  data-memory read data, passed through for other addresses
// iRd        in   1  one-iCLK read-consume strobe; edge-detected by the instantiating logic
// oRegData   out  8  read data toward the MemtoReg mux
// oRxByte    out  8  last accepted byte, for display
// oValid     out  1  unread byte held
// oOverrun   out  1  a byte was overwritten before being read
// oFrameErr  out  1  stop bit sampled low
// BEHAVIOUR
// - Reset (iRST_N=0 at iCLK edge): state IDLE, counters 0, both sync flops 1, hold register 0,
//   oValid/oOverrun/oFrameErr 0, oRxByte 0. A reset mid-frame discards the partial byte.
// - iRXD passes through a 2-flop synchronizer; all FSM decisions use the synchronized value (rxs).
// - FSM states: IDLE, START, DATA, STOP, WAIT_HI.
//   IDLE:    rxs==0 -> START, counter cleared.
//   START:   at counter == CLKS_PER_BIT/2-1 sample rxs. If 1 (glitch) -> IDLE; else -> DATA, counter
//            and bit index cleared.
//   DATA:    every CLKS_PER_BIT cycles sample one bit into shift[bit index], LSB first. After bit 7 -> STOP.
//   STOP:    after CLKS_PER_BIT cycles sample rxs. If 1: load the hold register and -> IDLE. If 0: set
//            oFrameErr, discard the byte, and -> WAIT_HI.
//   WAIT_HI: stay until rxs==1, then -> IDLE. This blocks false starts on a held-low line.
// - Byte load, in the cycle after the stop sample: hold <= shift, oValid <= 1. If oValid was already 1
//   and no DATA_ADDR consume occurs in the same cycle, oOverrun <= 1. New data always overwrites old.
// - Consume: iRd=1 with iAddress==DATA_ADDR clears oValid and oOverrun on the next edge.
//   iRd=1 with iAddress==STAT_ADDR clears oFrameErr.
// - Simultaneous load and DATA_ADDR consume: load wins, so oValid stays 1 and oOverrun is not set.
// - oRegData is combinational, zero latency:
//   iAddress==DATA_ADDR -> hold; iAddress==STAT_ADDR -> status; otherwise iMemData.
// - oRxByte == hold at all times. Every registered output changes only on iCLK edges.
// TESTING (CLK_FREQ=1000, BAUD=100, so CLKS_PER_BIT=10)
// - Reset: iRST_N=0 with iRXD toggling -> all outputs 0; oRegData follows iMemData=8'h5A at iAddress=8'h10.
// - Send 8'hA5 (start, 1,0,1,0,0,1,0,1, stop) -> oValid=1, oRxByte=A5.
//   iAddress=FE gives oRegData=A5; iAddress=FD gives 8'h01.
//   iRd at FE -> oValid=0 on the next edge.
// - Send 8'h11, then 8'h22 without reading -> oRxByte=22, status=8'h03.
//   iRd at FE -> status=8'h00.
// - Frame error: stop bit low, line held low 50 cycles, then high -> oFrameErr=1, oValid unchanged,
//   no new frame started while low. iRd at FD -> oFrameErr=0.
// - Glitch: iRXD low for 3 cycles -> FSM returns to IDLE, no flags set.
// - Corner cases: iRd at FE in the exact load cycle of a second byte -> oValid=1, oOverrun=0.
//   iRST_N=0 mid-DATA, then a clean frame 8'h3C -> received correctly.

Source files
------------

// File: rtl/uart_rx_port.sv
// Memory-mapped 8N1 UART receive port: the CPU reads the received byte and a status word with ordinary loads,
// and any other address passes data-memory read data through to the MemtoReg mux.
module uart_rx_port #(
  parameter int         CLK_FREQ  = 50000000,
  parameter int         BAUD      = 115200,
  parameter logic [7:0] DATA_ADDR = 8'hFE,
  parameter logic [7:0] STAT_ADDR = 8'hFD
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iRXD,
  input  logic [7:0] iAddress,
  input  logic [7:0] iMemData,
  input  logic       iRd,
  output logic [7:0] oRegData,
  output logic [7:0] oRxByte,
  output logic       oValid,
  output logic       oOverrun,
  output logic       oFrameErr,
  output logic [2:0] oDbgState
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB + 1);
  localparam logic [CW-1:0] C_FULL = CW'(CPB - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CPB / 2 - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HI} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_sync1, r_sync2;
  logic          r_load;
  logic [7:0]    r_hold;
  logic          r_valid, r_ovr, r_ferr;

  state_t        w_state_nx;
  logic [CW-1:0] w_cnt_nx;
  logic [2:0]    w_bit_nx;
  logic [7:0]    w_shift_nx;
  logic          w_load_nx;
  logic          w_ferr_set;
  logic          w_rxs;
  logic          w_rd_data, w_rd_stat;

  assign w_rxs     = r_sync2;
  assign w_rd_data = iRd && (iAddress == DATA_ADDR);
  assign w_rd_stat = iRd && (iAddress == STAT_ADDR);

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt + 1'b1;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_load_nx  = 1'b0;
    w_ferr_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        if (!w_rxs) w_state_nx = S_START;
      end
      S_START: begin
        // Mid-start-bit check rejects short glitches on the line
        if (r_cnt == C_HALF) begin
          w_cnt_nx   = '0;
          w_bit_nx   = 3'd0;
          w_state_nx = w_rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == C_FULL) begin
          w_cnt_nx          = '0;
          w_shift_nx[r_bit] = w_rxs;
          if (r_bit == 3'd7) w_state_nx = S_STOP;
          else               w_bit_nx   = r_bit + 3'd1;
        end
      end
      S_STOP: begin
        if (r_cnt == C_FULL) begin
          w_cnt_nx = '0;
          if (w_rxs) begin
            w_load_nx  = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_ferr_set = 1'b1;
            w_state_nx = S_WAIT_HI;
          end
        end
      end
      S_WAIT_HI: begin
        w_cnt_nx = '0;
        if (w_rxs) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_load  <= 1'b0;
      r_hold  <= 8'h00;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync1 <= iRXD;
      r_sync2 <= r_sync1;
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
      r_load  <= w_load_nx;
      // A load beats a same-cycle consume; overrun only when unread data is lost
      if (r_load) begin
        r_hold  <= r_shift;
        r_valid <= 1'b1;
        r_ovr   <= w_rd_data ? 1'b0 : (r_valid | r_ovr);
      end else if (w_rd_data) begin
        r_valid <= 1'b0;
        r_ovr   <= 1'b0;
      end
      if (w_ferr_set)     r_ferr <= 1'b1;
      else if (w_rd_stat) r_ferr <= 1'b0;
    end
  end

  always_comb begin
    oRegData = iMemData;
    if (iAddress == DATA_ADDR)      oRegData = r_hold;
    else if (iAddress == STAT_ADDR) oRegData = {5'b0, r_ferr, r_ovr, r_valid};
  end

  assign oRxByte   = r_hold;
  assign oValid    = r_valid;
  assign oOverrun  = r_ovr;
  assign oFrameErr = r_ferr;
  assign oDbgState = r_state;

endmodule

// File: tb/tb_uart_rx_port.sv
// Directed bench for uart_rx_port: an event-level model of the receive port, checked against the DUT
// on every quiet cycle, plus literal expectations after each scenario.
module tb_uart_rx_port;
  // Handshake: iRd is a one-cycle consume strobe qualified by iAddress; no backpressure exists.
  logic       iCLK = 1'b0;
  logic       iRST_N, iRXD, iRd;
  logic [7:0] iAddress, iMemData;
  logic [7:0] oRegData, oRxByte;
  logic       oValid, oOverrun, oFrameErr;
  logic [2:0] oDbgState;

  int n_vec = 0;
  int n_err = 0;

  // Model of the port as seen by software
  logic       m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;
  logic [7:0] m_hold = 8'h00;
  logic       chk_en = 1'b0;

  uart_rx_port #(.CLK_FREQ(1000), .BAUD(100), .DATA_ADDR(8'hFE), .STAT_ADDR(8'hFD)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iRXD(iRXD), .iAddress(iAddress), .iMemData(iMemData), .iRd(iRd),
    .oRegData(oRegData), .oRxByte(oRxByte), .oValid(oValid), .oOverrun(oOverrun),
    .oFrameErr(oFrameErr), .oDbgState(oDbgState)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_regdata(input logic [7:0] addr, input logic [7:0] mem);
    if (addr == 8'hFE)      return m_hold;
    else if (addr == 8'hFD) return {5'b0, m_ferr, m_ovr, m_valid};
    else                    return mem;
  endfunction

  // Compare process: outputs are stable mid-cycle
  always @(negedge iCLK) begin
    if (chk_en) begin
      check("valid",   {7'b0, oValid},    {7'b0, m_valid});
      check("overrun", {7'b0, oOverrun},  {7'b0, m_ovr});
      check("frmerr",  {7'b0, oFrameErr}, {7'b0, m_ferr});
      check("rxbyte",  oRxByte, m_hold);
      check("regdata", oRegData, model_regdata(iAddress, iMemData));
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic model_load(input logic [7:0] b, input logic consumed);
    if (consumed)     m_ovr = 1'b0;
    else if (m_valid) m_ovr = 1'b1;
    m_valid = 1'b1;
    m_hold  = b;
  endtask

  task automatic do_read(input logic [7:0] addr);
    iAddress = addr;
    iRd      = 1'b1;
    tick();
    iRd = 1'b0;
    if (addr == 8'hFE) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    if (addr == 8'hFD) m_ferr = 1'b0;
  endtask

  // One 100-cycle frame; rd_load pulses a FE consume on the edge where the byte is loaded (edge 99)
  task automatic send_frame(input logic [7:0] data, input logic stop, input logic rd_load);
    logic [7:0] d;
    d = data;
    chk_en = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (c < 10)      iRXD = 1'b0;
      else if (c < 90) iRXD = d[c/10-1];
      else             iRXD = stop;
      iRd      = rd_load && (c == 98);
      iAddress = (rd_load && (c == 98)) ? 8'hFE : 8'h10;
      tick();
    end
    iRd      = 1'b0;
    iAddress = 8'h10;
  endtask

  task automatic send_byte(input logic [7:0] data, input logic rd_load);
    send_frame(data, 1'b1, rd_load);
    idle(5);
    model_load(data, rd_load);
    chk_en = 1'b1;
    idle(3);
  endtask

  initial begin
    iRST_N = 1'b0; iRXD = 1'b1; iRd = 1'b0; iAddress = 8'h10; iMemData = 8'h5A;
    // Reset with a toggling line
    for (int i = 0; i < 6; i++) begin
      iRXD = ~iRXD;
      tick();
    end
    check("rst_valid",   {7'b0, oValid},    8'h00);
    check("rst_ovr",     {7'b0, oOverrun},  8'h00);
    check("rst_ferr",    {7'b0, oFrameErr}, 8'h00);
    check("rst_rxbyte",  oRxByte, 8'h00);
    check("rst_regdata", oRegData, 8'h5A);
    iRXD = 1'b1;
    iRST_N = 1'b1;
    chk_en = 1'b1;
    idle(5);

    // Single byte, then status and data reads
    send_byte(8'hA5, 1'b0);
    check("a5_valid", {7'b0, oValid}, 8'h01);
    check("a5_rxbyte", oRxByte, 8'hA5);
    iAddress = 8'hFE; tick();
    check("a5_data", oRegData, 8'hA5);
    iAddress = 8'hFD; tick();
    check("a5_stat", oRegData, 8'h01);
    do_read(8'hFE);
    check("a5_consumed", {7'b0, oValid}, 8'h00);
    iAddress = 8'h10; idle(3);

    // Overrun
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    check("ovr_rxbyte", oRxByte, 8'h22);
    iAddress = 8'hFD; tick();
    check("ovr_stat", oRegData, 8'h03);
    do_read(8'hFE);
    iAddress = 8'hFD; tick();
    check("ovr_cleared", oRegData, 8'h00);

    // Framing error with the line held low afterwards
    send_byte(8'h5C, 1'b0);
    send_frame(8'h77, 1'b0, 1'b0);
    m_ferr = 1'b1;
    chk_en = 1'b1;
    idle(50);
    iRXD = 1'b1;
    idle(120);
    check("fe_flag", {7'b0, oFrameErr}, 8'h01);
    check("fe_valid", {7'b0, oValid}, 8'h01);
    check("fe_rxbyte", oRxByte, 8'h5C);
    do_read(8'hFD);
    check("fe_cleared", {7'b0, oFrameErr}, 8'h00);
    do_read(8'hFE);
    iAddress = 8'h10; idle(3);

    // Three-cycle glitch must not start a frame
    iRXD = 1'b0; idle(3);
    iRXD = 1'b1; idle(30);
    iAddress = 8'hFD; tick();
    check("glitch_stat", oRegData, 8'h00);
    iAddress = 8'h10; tick();

    // Consume in the exact load cycle of a second byte
    send_byte(8'h81, 1'b0);
    send_byte(8'h42, 1'b1);
    check("race_valid", {7'b0, oValid}, 8'h01);
    check("race_ovr", {7'b0, oOverrun}, 8'h00);
    check("race_rxbyte", oRxByte, 8'h42);
    do_read(8'hFE);
    iAddress = 8'h10; tick();

    // Reset mid-DATA, then a clean frame
    chk_en = 1'b0;
    for (int c = 0; c < 45; c++) begin
      iRXD = (c < 10) ? 1'b0 : c[0];
      tick();
    end
    iRXD = 1'b1;
    iRST_N = 1'b0;
    idle(3);
    iRST_N = 1'b1;
    m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_hold = 8'h00;
    chk_en = 1'b1;
    idle(20);
    send_byte(8'h3C, 1'b0);
    check("mid_rst_rxbyte", oRxByte, 8'h3C);
    check("mid_rst_valid", {7'b0, oValid}, 8'h01);
    iAddress = 8'hFD; tick();
    check("mid_rst_stat", oRegData, 8'h01);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
